universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the register width in bits (legal range 2..64).
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), SHALL set the shift-amount width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  SHALL indicate a command is presented.
REQ-006 cmd_ready  output  1  SHALL indicate the block accepts a command this cycle.
REQ-007 cmd_op  input  3  SHALL select the operation: 0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR.
REQ-008 cmd_amt  input  CNT_W  SHALL give the shift count for ops 2..6; ignored otherwise.
REQ-009 load_d  input  WIDTH  SHALL supply the parallel-load value.
REQ-010 sin  input  1  SHALL supply the serial fill bit for SHL (enters bit 0) and SHR (enters bit WIDTH-1).
REQ-011 q  output  WIDTH  SHALL present the registered contents.
REQ-012 qb  output  WIDTH  SHALL always equal ~q.
REQ-013 sout  output  1  SHALL present the bit expelled or rotated out by the most recent single shift.
REQ-014 busy  output  1  SHALL be high while a multi-cycle shift is in progress.
REQ-015 done  output  1  SHALL pulse high for exactly one cycle when a command's result first appears on q.

Function
REQ-016 cmd_ready SHALL equal !busy; a command is accepted on a rising edge where cmd_valid && cmd_ready.
REQ-017 cmd_valid while busy SHALL be ignored; no command is queued.
REQ-018 FSM states SHALL be IDLE and SHIFT; reset state IDLE; busy = (state == SHIFT).
REQ-019 LOAD SHALL write load_d into q on the accept edge; done high in the following cycle.
REQ-020 CLR SHALL write 0 into q and sout on the accept edge; done high in the following cycle.
REQ-021 NOP, and any shift op with cmd_amt = 0, SHALL leave q and sout unchanged; done high in the following cycle.
REQ-022 A shift op with cmd_amt = N >= 1 SHALL perform one single-bit step on the accept edge and one on each of the next N-1 edges.
REQ-023 For N >= 2 the FSM SHALL enter SHIFT on the accept edge and return to IDLE on the edge that performs step N.
REQ-024 done SHALL be high in the cycle after step N, and busy SHALL be low in that same cycle.
REQ-025 op, amt and the remaining count SHALL be latched at accept; changes to cmd_op or cmd_amt during SHIFT SHALL have no effect.
REQ-026 sin SHALL be sampled live at each step, so SHL and SHR act as a serial-in feed.
REQ-027 Step rules: SHL = {q[W-2:0],sin}; SHR = {sin,q[W-1:1]}; ROL = {q[W-2:0],q[W-1]}; ROR = {q[0],q[W-1:1]}; ASR = {q[W-1],q[W-1:1]}.
REQ-028 On each step, sout SHALL capture q[W-1] for SHL and ROL, and q[0] for SHR, ROR and ASR.
REQ-029 cmd_amt > WIDTH SHALL be executed literally, with no clamping (e.g. ROL by WIDTH returns the original value).
REQ-030 A command SHALL be acceptable in the same cycle that done is high.

Reset
REQ-031 While rst is high, q SHALL be 0, qb all ones, sout 0, busy 0, done 0, state IDLE, remaining count 0, and cmd_ready 1; this takes effect immediately, without waiting for clk.
REQ-032 rst asserted mid-SHIFT SHALL abort the command with no done pulse.

Structure
REQ-033 Package usr_pkg SHALL hold the op-encoding enum, the FSM state typedef and the width-clog2 helper.
REQ-034 The single-step next-value and sout logic SHALL be a combinational sub-module usr_step (WIDTH parameter); universal_shift_reg SHALL hold the FSM, counter and registers.

Verification (WIDTH=8)
REQ-035 LOAD 0xA5 -> next cycle q=0xA5, qb=0x5A, done=1 for one cycle, busy=0.
REQ-036 q=0xA5, ROL amt=3 -> busy high 2 cycles, then q=0x2D, sout=1, done=1.
REQ-037 q=0x96, ASR amt=2 -> q=0xE5, sout=1, done once.
REQ-038 q=0x00, SHR amt=4 with sin=1, and a second cmd_valid asserted during busy -> q=0xF0, second command ignored, cmd_ready=0 throughout busy.
REQ-039 q=0x3C, SHL amt=0 -> q=0x3C unchanged, done next cycle, busy never high.
REQ-040 SHL amt=5 from q=0xFF, rst raised after 2 steps -> q=0x00, busy=0 immediately, no done, next LOAD accepted normally.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
// Holds the command op encoding, the FSM state type and a width helper.
package usr_pkg;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpLoad = 3'd1,
    OpShl  = 3'd2,
    OpShr  = 3'd3,
    OpRol  = 3'd4,
    OpRor  = 3'd5,
    OpAsr  = 3'd6,
    OpClr  = 3'd7
  } usr_op_e;

  typedef enum logic {
    StIdle,
    StShift
  } usr_state_e;

  // Smallest r with 2**r >= v.
  function automatic int unsigned usr_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic logic usr_is_shift(input usr_op_e op);
    return (op == OpShl) || (op == OpShr) || (op == OpRol) || (op == OpRor) || (op == OpAsr);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Single-bit shift/rotate step: next register value and the bit pushed out.
module usr_step
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  usr_op_e          op_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_o
);

  always_comb begin
    q_o    = q_i;
    sout_o = 1'b0;
    case (op_i)
      OpShl: begin
        q_o    = {q_i[WIDTH-2:0], sin_i};
        sout_o = q_i[WIDTH-1];
      end
      OpShr: begin
        q_o    = {sin_i, q_i[WIDTH-1:1]};
        sout_o = q_i[0];
      end
      OpRol: begin
        q_o    = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        sout_o = q_i[WIDTH-1];
      end
      OpRor: begin
        q_o    = {q_i[0], q_i[WIDTH-1:1]};
        sout_o = q_i[0];
      end
      OpAsr: begin
        q_o    = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        sout_o = q_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with a valid/ready command port and multi-cycle shifts.
// One bit moves per clock; op and remaining count are latched at accept.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = usr_clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] load_d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  usr_state_e       state_q, state_d;
  usr_op_e          op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  usr_op_e          cmd_op_e;
  usr_op_e          step_op;
  logic [WIDTH-1:0] step_q;
  logic             step_sout;
  logic             accept;

  assign cmd_op_e = usr_op_e'(cmd_op);
  assign accept   = cmd_valid && (state_q == StIdle);
  // The first step runs on the accept edge, so the step unit sees the live op then.
  assign step_op  = (state_q == StShift) ? op_q : cmd_op_e;

  usr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i   (step_op),
    .q_i    (q_q),
    .sin_i  (sin),
    .q_o    (step_q),
    .sout_o (step_sout)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (usr_is_shift(cmd_op_e) && (cmd_amt != '0)) begin
            q_d    = step_q;
            sout_d = step_sout;
            if (cmd_amt == CNT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d = StShift;
              op_d    = cmd_op_e;
              rem_d   = cmd_amt - CNT_W'(1);
            end
          end else begin
            done_d = 1'b1;
            case (cmd_op_e)
              OpLoad: q_d = load_d;
              OpClr: begin
                q_d    = '0;
                sout_d = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      StShift: begin
        q_d    = step_q;
        sout_d = step_sout;
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      rem_q   <= '0;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign q         = q_q;
  assign qb        = ~q_q;
  assign sout      = sout_q;
  assign busy      = (state_q == StShift);
  assign cmd_ready = ~busy;
  assign done      = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8.
module tb_universal_shift_reg;

  localparam int unsigned Width = 8;
  localparam int unsigned CntW  = 4;

  localparam logic [2:0] Nop = 3'd0, Load = 3'd1, Shl = 3'd2, Shr = 3'd3;
  localparam logic [2:0] Rol = 3'd4, Ror = 3'd5, Asr = 3'd6, Clr = 3'd7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [2:0]      cmd_op = 3'd0;
  logic [CntW-1:0] cmd_amt = '0;
  logic [Width-1:0] load_d = '0;
  logic            sin = 1'b0;
  logic [Width-1:0] q, qb;
  logic            sout, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  universal_shift_reg #(
    .WIDTH (Width),
    .CNT_W (CntW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .load_d    (load_d),
    .sin       (sin),
    .q         (q),
    .qb        (qb),
    .sout      (sout),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one accept edge.
  task automatic issue(input logic [2:0] op, input logic [CntW-1:0] amt,
                       input logic [Width-1:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    load_d    = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int cycles;

    #2;
    check_eq("rst_q", q, 8'h00);
    check_eq("rst_qb", qb, 8'hFF);
    check_eq("rst_sout", sout, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ready", cmd_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    issue(Load, 4'd0, 8'hA5);
    check_eq("load_q", q, 8'hA5);
    check_eq("load_qb", qb, 8'h5A);
    check_eq("load_done", done, 1'b1);
    check_eq("load_busy", busy, 1'b0);
    tick();
    check_eq("load_done_drop", done, 1'b0);

    issue(Rol, 4'd3, 8'h00);
    check_eq("rol3_busy1", busy, 1'b1);
    check_eq("rol3_ready1", cmd_ready, 1'b0);
    check_eq("rol3_done1", done, 1'b0);
    check_eq("rol3_q1", q, 8'h4B);
    tick();
    check_eq("rol3_busy2", busy, 1'b1);
    tick();
    check_eq("rol3_busy3", busy, 1'b0);
    check_eq("rol3_q", q, 8'h2D);
    check_eq("rol3_sout", sout, 1'b1);
    check_eq("rol3_done", done, 1'b1);
    tick();
    check_eq("rol3_done_drop", done, 1'b0);

    issue(Load, 4'd0, 8'h96);
    issue(Asr, 4'd2, 8'h00);
    check_eq("asr_q1", q, 8'hCB);
    check_eq("asr_done1", done, 1'b0);
    tick();
    check_eq("asr_q", q, 8'hE5);
    check_eq("asr_sout", sout, 1'b1);
    check_eq("asr_done", done, 1'b1);
    tick();
    check_eq("asr_done_drop", done, 1'b0);

    issue(Load, 4'd0, 8'h00);
    sin = 1'b1;
    issue(Shr, 4'd4, 8'h00);
    check_eq("shr_q1", q, 8'h80);
    // Competing command held valid through the busy window.
    cmd_valid = 1'b1;
    cmd_op    = Load;
    cmd_amt   = 4'd1;
    load_d    = 8'h55;
    check_eq("shr_ready1", cmd_ready, 1'b0);
    tick();
    check_eq("shr_ready2", cmd_ready, 1'b0);
    check_eq("shr_q2", q, 8'hC0);
    tick();
    check_eq("shr_ready3", cmd_ready, 1'b0);
    tick();
    cmd_valid = 1'b0;
    sin = 1'b0;
    check_eq("shr_q", q, 8'hF0);
    check_eq("shr_done", done, 1'b1);
    check_eq("shr_busy", busy, 1'b0);
    tick();
    check_eq("shr_ignored", q, 8'hF0);

    issue(Load, 4'd0, 8'h3C);
    check_eq("ld3c_done", done, 1'b1);
    issue(Shl, 4'd0, 8'h00);
    check_eq("shl0_q", q, 8'h3C);
    check_eq("shl0_done", done, 1'b1);
    check_eq("shl0_busy", busy, 1'b0);
    tick();
    check_eq("shl0_busy2", busy, 1'b0);

    issue(Load, 4'd0, 8'h01);
    issue(Ror, 4'd1, 8'h00);
    check_eq("ror1_q", q, 8'h80);
    check_eq("ror1_sout", sout, 1'b1);
    check_eq("ror1_done", done, 1'b1);
    check_eq("ror1_busy", busy, 1'b0);
    issue(Nop, 4'd3, 8'hAA);
    check_eq("nop_q", q, 8'h80);
    check_eq("nop_sout", sout, 1'b1);
    check_eq("nop_done", done, 1'b1);
    issue(Clr, 4'd2, 8'hAA);
    check_eq("clr_q", q, 8'h00);
    check_eq("clr_sout", sout, 1'b0);
    sin = 1'b1;
    issue(Shr, 4'd1, 8'h00);
    sin = 1'b0;
    check_eq("shr1_q", q, 8'h80);
    check_eq("shr1_sout", sout, 1'b0);

    issue(Load, 4'd0, 8'hFF);
    issue(Shl, 4'd5, 8'h00);
    tick();
    check_eq("abort_q_pre", q, 8'hFC);
    check_eq("abort_busy_pre", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_q", q, 8'h00);
    check_eq("abort_qb", qb, 8'hFF);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_ready", cmd_ready, 1'b1);
    check_eq("abort_done", done, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("abort_no_done1", done, 1'b0);
    tick();
    check_eq("abort_no_done2", done, 1'b0);
    issue(Load, 4'd0, 8'h5A);
    check_eq("post_abort_q", q, 8'h5A);
    check_eq("post_abort_done", done, 1'b1);

    issue(Rol, 4'd8, 8'h00);
    // Command inputs change mid-shift; the latched op/count must win.
    cmd_op  = Clr;
    cmd_amt = 4'd1;
    cycles  = 1;
    while (!done && cycles < 20) begin
      tick();
      cycles++;
    end
    check_eq("rol8_cycles", cycles, 8);
    check_eq("rol8_q", q, 8'h5A);
    check_eq("rol8_sout", sout, 1'b0);
    check_eq("rol8_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
